// File: rtl/zxuno_regbus_pkg.sv
// rtl/zxuno_regbus_pkg.sv - shared constants and types for the ZX-UNO register bus
// Contents:
//   port addresses of the register-select and register-data ports,
//   well-known register numbers, the idle bus byte, sequencer state enum.
package zxuno_regbus_pkg;

  localparam logic [15:0] ZXUNO_ADDR_PORT = 16'hFC3B;
  localparam logic [15:0] ZXUNO_DATA_PORT = 16'hFD3B;

  localparam logic [7:0] REG_MASTERCONF  = 8'h00;
  localparam logic [7:0] REG_SCANDBLCTRL = 8'h0B;
  localparam logic [7:0] REG_COREID      = 8'hFF;

  // Byte the CPU sees when nobody drives the data bus.
  localparam logic [7:0] REGBUS_IDLE_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUAL  = 2'd1,
    DO_WR = 2'd2,
    HOLD  = 2'd3
  } regbus_state_e;

  typedef enum logic {
    PORT_ADDR = 1'b0,
    PORT_DATA = 1'b1
  } regbus_port_e;

endpackage

// File: rtl/zxuno_rdmux.sv
// rtl/zxuno_rdmux.sv - priority read mux and claim counter for peripheral read responses
// Ports:
//   dev_dout    in  8*NDEV  device read data, device i at [8i+7:8i]
//   dev_oe_n    in  NDEV    device read enables, active low
//   sel_byte    out 8       data of the lowest-index claiming device
//   any_claim   out 1       at least one device claims the read
//   multi_claim out 1       two or more devices claim the read
module zxuno_rdmux
  import zxuno_regbus_pkg::*;
#(
  parameter int NDEV = 4
) (
  input  logic [8*NDEV-1:0] dev_dout,
  input  logic [NDEV-1:0]   dev_oe_n,
  output logic [7:0]        sel_byte,
  output logic              any_claim,
  output logic              multi_claim
);

  // NDEV is at most 8, so four bits hold the claim count.
  logic [3:0] claims;

  // Scan from the top index down so the lowest claiming index is the last
  // assignment and therefore wins.
  always_comb begin
    sel_byte = REGBUS_IDLE_BYTE;
    claims   = 4'd0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (!dev_oe_n[i]) begin
        sel_byte = dev_dout[8*i +: 8];
        claims   = claims + 4'd1;
      end
    end
  end

  assign any_claim   = (claims != 4'd0);
  assign multi_claim = (claims > 4'd1);

endmodule

// File: rtl/zxuno_regport_ctrl.sv
// rtl/zxuno_regport_ctrl.sv - ZX-UNO register bus sequencer and CPU read arbiter
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   a, iorq_n, rd_n,
//   wr_n, din           Z80 I/O cycle inputs
//   dout, oe_n          CPU read data and its active-low valid
//   zxuno_addr          selected register number
//   zxuno_regrd         level, data-port read in progress
//   zxuno_regwr         one-cycle data-port write strobe
//   regaddr_changed     one-cycle pulse on every register-select write
//   dev_dout, dev_oe_n  peripheral read responses
//   rd_conflict         sticky, more than one device claimed a read
module zxuno_regport_ctrl
  import zxuno_regbus_pkg::*;
#(
  parameter logic [15:0] ADDR_PORT = ZXUNO_ADDR_PORT,
  parameter logic [15:0] DATA_PORT = ZXUNO_DATA_PORT,
  parameter int          NDEV      = 4,
  parameter logic [7:0]  IDLE_BYTE = REGBUS_IDLE_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       a,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              oe_n,
  output logic [7:0]        zxuno_addr,
  output logic              zxuno_regrd,
  output logic              zxuno_regwr,
  output logic              regaddr_changed,
  input  logic [8*NDEV-1:0] dev_dout,
  input  logic [NDEV-1:0]   dev_oe_n,
  output logic              rd_conflict
);

  logic io_rd, io_wr, rd_dec, hit_a, hit_d, port_match;

  regbus_state_e state_q, state_d;
  regbus_port_e  port_q, port_d;

  logic [7:0] addr_q, addr_d;
  logic       regrd_q, regrd_d;
  logic       regwr_q, regwr_d;
  logic       chg_q, chg_d;
  logic       conflict_q, conflict_d;

  logic [7:0] mux_byte;
  logic       any_claim, multi_claim;
  logic       rd_sel;

  assign io_rd = ~iorq_n & ~rd_n;
  assign io_wr = ~iorq_n & ~wr_n;
  // A cycle with both strobes low is a write; the read side stays quiet.
  assign rd_dec = io_rd & ~io_wr;
  assign hit_a  = (a == ADDR_PORT);
  assign hit_d  = (a == DATA_PORT);

  // The write must still target the port latched in IDLE to qualify.
  assign port_match = (port_q == PORT_DATA) ? hit_d : hit_a;

  zxuno_rdmux #(
    .NDEV(NDEV)
  ) u_rdmux (
    .dev_dout   (dev_dout),
    .dev_oe_n   (dev_oe_n),
    .sel_byte   (mux_byte),
    .any_claim  (any_claim),
    .multi_claim(multi_claim)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      port_q  <= PORT_ADDR;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    case (state_q)
      IDLE: begin
        if (io_wr && (hit_a || hit_d)) begin
          state_d = QUAL;
          port_d  = hit_d ? PORT_DATA : PORT_ADDR;
        end else if (rd_dec && hit_d) begin
          state_d = HOLD;
        end
      end
      QUAL: begin
        if (io_wr && port_match) state_d = DO_WR;
        else                     state_d = IDLE;
      end
      DO_WR: state_d = HOLD;
      HOLD: begin
        // Wait out the rest of the CPU cycle so a long cycle strobes once.
        if (!(io_rd || io_wr)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    regrd_d    = ((state_q == IDLE) && (state_d == HOLD)) ||
                 ((state_q == HOLD) && (state_d == HOLD) && regrd_q);
    regwr_d    = (state_q == DO_WR) && (port_q == PORT_DATA);
    chg_d      = (state_q == DO_WR) && (port_q == PORT_ADDR);
    addr_d     = chg_d ? din : addr_q;
    conflict_d = conflict_q | (rd_dec & hit_d & multi_claim);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= 8'h00;
      regrd_q    <= 1'b0;
      regwr_q    <= 1'b0;
      chg_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      regrd_q    <= regrd_d;
      regwr_q    <= regwr_d;
      chg_q      <= chg_d;
      conflict_q <= conflict_d;
    end
  end

  // Combinational read path; held off while in reset so the bus stays idle.
  assign rd_sel = rd_dec & (hit_a | hit_d) & ~rst;

  always_comb begin
    oe_n = ~rd_sel;
    dout = IDLE_BYTE;
    if (rd_sel) begin
      if (hit_a)          dout = addr_q;
      else if (any_claim) dout = mux_byte;
      else                dout = IDLE_BYTE;
    end
  end

  assign zxuno_addr      = addr_q;
  assign zxuno_regrd     = regrd_q;
  assign zxuno_regwr     = regwr_q;
  assign regaddr_changed = chg_q;
  assign rd_conflict     = conflict_q;

endmodule

// File: tb/tb_zxuno_regport_ctrl.sv
// tb/tb_zxuno_regport_ctrl.sv - scoreboard bench for zxuno_regport_ctrl
module tb_zxuno_regport_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic        iorq_n, rd_n, wr_n;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        oe_n;
  logic [7:0]  zxuno_addr;
  logic        zxuno_regrd, zxuno_regwr, regaddr_changed;
  logic [31:0] dev_dout;
  logic [3:0]  dev_oe_n;
  logic        rd_conflict;

  always #5 clk = ~clk;

  zxuno_regport_ctrl #(
    .ADDR_PORT(16'hFC3B),
    .DATA_PORT(16'hFD3B),
    .NDEV     (4),
    .IDLE_BYTE(8'hFF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .a              (a),
    .iorq_n         (iorq_n),
    .rd_n           (rd_n),
    .wr_n           (wr_n),
    .din            (din),
    .dout           (dout),
    .oe_n           (oe_n),
    .zxuno_addr     (zxuno_addr),
    .zxuno_regrd    (zxuno_regrd),
    .zxuno_regwr    (zxuno_regwr),
    .regaddr_changed(regaddr_changed),
    .dev_dout       (dev_dout),
    .dev_oe_n       (dev_oe_n),
    .rd_conflict    (rd_conflict)
  );

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push_exp(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [7:0] obs);
    exp_t e;
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL scoreboard_empty: got %02h want queued entry", obs);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: got %02h want %02h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic bus_idle();
    iorq_n   = 1'b1;
    rd_n     = 1'b1;
    wr_n     = 1'b1;
    dev_oe_n = 4'hF;
  endtask

  task automatic push_reset_values(input string pfx);
    push_exp({pfx, "_addr"}, 8'h00);
    push_exp({pfx, "_regrd"}, 8'h00);
    push_exp({pfx, "_regwr"}, 8'h00);
    push_exp({pfx, "_chg"}, 8'h00);
    push_exp({pfx, "_oe_n"}, 8'h01);
    push_exp({pfx, "_dout"}, 8'hFF);
    push_exp({pfx, "_conflict"}, 8'h00);
  endtask

  task automatic pop_reset_values();
    pop_chk(zxuno_addr);
    pop_chk({7'd0, zxuno_regrd});
    pop_chk({7'd0, zxuno_regwr});
    pop_chk({7'd0, regaddr_changed});
    pop_chk({7'd0, oe_n});
    pop_chk(dout);
    pop_chk({7'd0, rd_conflict});
  endtask

  // Write cycle held for nclk sampled clocks; strobe index counts clocks
  // after the drive point, first sampling edge being 1.
  task automatic do_write(input logic [15:0] addr, input logic [7:0] data,
                          input int nclk, input logic with_rd,
                          input logic [7:0] exp_chg, input logic [7:0] exp_wr,
                          input logic [7:0] exp_idx, input logic [7:0] exp_addr);
    logic [7:0] n_chg, n_wr, n_rd, idx;
    n_chg = 8'd0; n_wr = 8'd0; n_rd = 8'd0; idx = 8'd0;
    push_exp("wr_oe_n", 8'h01);
    push_exp("wr_chg_cnt", exp_chg);
    push_exp("wr_regwr_cnt", exp_wr);
    push_exp("wr_regrd_cnt", 8'd0);
    push_exp("wr_strobe_idx", exp_idx);
    push_exp("wr_addr_after", exp_addr);
    @(posedge clk); #2;
    a = addr; din = data; iorq_n = 1'b0; wr_n = 1'b0; rd_n = !with_rd;
    @(negedge clk);
    pop_chk({7'd0, oe_n});
    for (int k = 1; k <= nclk + 3; k++) begin
      @(posedge clk); @(negedge clk);
      if (regaddr_changed) begin
        n_chg++;
        if (idx == 8'd0) idx = 8'(k);
      end
      if (zxuno_regwr) begin
        n_wr++;
        if (idx == 8'd0) idx = 8'(k);
      end
      if (zxuno_regrd) n_rd++;
      if (k == nclk) bus_idle();
    end
    pop_chk(n_chg);
    pop_chk(n_wr);
    pop_chk(n_rd);
    pop_chk(idx);
    pop_chk(zxuno_addr);
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [3:0] oe_mask,
                         input int nclk, input logic [7:0] exp_dout,
                         input logic [7:0] exp_rd_cnt, input logic exp_conf);
    logic [7:0] n_rd;
    logic       rd_after;
    n_rd = 8'd0; rd_after = 1'b1;
    push_exp("rd_oe_n", 8'h00);
    push_exp("rd_dout", exp_dout);
    push_exp("rd_regrd_cnt", exp_rd_cnt);
    push_exp("rd_regrd_after", 8'h00);
    push_exp("rd_conflict", {7'd0, exp_conf});
    @(posedge clk); #2;
    a = addr; dev_oe_n = oe_mask; iorq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    pop_chk({7'd0, oe_n});
    pop_chk(dout);
    for (int k = 1; k <= nclk + 2; k++) begin
      @(posedge clk); @(negedge clk);
      if (k <= nclk && zxuno_regrd) n_rd++;
      if (k == nclk + 1) rd_after = zxuno_regrd;
      if (k == nclk) bus_idle();
    end
    pop_chk(n_rd);
    pop_chk({7'd0, rd_after});
    pop_chk({7'd0, rd_conflict});
  endtask

  initial begin
    logic [7:0] n_post;
    rst      = 1'b1;
    a        = 16'h0000;
    din      = 8'h00;
    dev_dout = 32'h9977_5431;
    bus_idle();

    repeat (2) @(posedge clk);
    @(negedge clk);
    push_reset_values("por");
    pop_reset_values();
    @(posedge clk); #2;
    rst = 1'b0;

    // Select register FFh with a 4-clock OUT.
    do_write(16'hFC3B, 8'hFF, 4, 1'b0, 8'd1, 8'd0, 8'd3, 8'hFF);
    // IN from the select port reads back the register number, no regrd.
    do_read(16'hFC3B, 4'hF, 3, 8'hFF, 8'd0, 1'b0);
    // One-clock write glitch on the data port: filtered.
    do_write(16'hFD3B, 8'h12, 1, 1'b0, 8'd0, 8'd0, 8'd0, 8'hFF);
    // Foreign port: ignored.
    do_write(16'hFE00, 8'h77, 4, 1'b0, 8'd0, 8'd0, 8'd0, 8'hFF);
    // Select 0Bh, then write data 5Ah for 6 clocks.
    do_write(16'hFC3B, 8'h0B, 2, 1'b0, 8'd1, 8'd0, 8'd3, 8'h0B);
    do_write(16'hFD3B, 8'h5A, 6, 1'b0, 8'd0, 8'd1, 8'd3, 8'h0B);
    // Data-port reads: single claim, double claim, no claim.
    do_read(16'hFD3B, 4'b1101, 3, 8'h54, 8'd3, 1'b0);
    do_read(16'hFD3B, 4'b1100, 2, 8'h31, 8'd2, 1'b1);
    do_read(16'hFD3B, 4'b1111, 2, 8'hFF, 8'd2, 1'b1);
    do_read(16'hFC3B, 4'hF, 1, 8'h0B, 8'd0, 1'b1);
    // Rewriting the same register number still pulses.
    do_write(16'hFC3B, 8'h0B, 3, 1'b0, 8'd1, 8'd0, 8'd3, 8'h0B);
    // RD and WR together count as a write.
    do_write(16'hFD3B, 8'hA5, 3, 1'b1, 8'd0, 8'd1, 8'd3, 8'h0B);

    // Reset in the middle of a data-port read held in HOLD.
    @(posedge clk); #2;
    a = 16'hFD3B; dev_oe_n = 4'b1101; iorq_n = 1'b0; rd_n = 1'b0;
    @(posedge clk); #2;
    push_exp("pre_rst_regrd", 8'h01);
    pop_chk({7'd0, zxuno_regrd});
    rst = 1'b1;
    #1;
    push_reset_values("mid_rst");
    pop_reset_values();
    @(posedge clk); #2;
    bus_idle();
    @(posedge clk); #2;
    rst = 1'b0;
    n_post = 8'd0;
    push_exp("post_rst_strobes", 8'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_post = n_post + {7'd0, zxuno_regrd} + {7'd0, zxuno_regwr} + {7'd0, regaddr_changed};
    end
    pop_chk(n_post);
    // Sequencer must be back in IDLE and accept a normal write.
    do_write(16'hFC3B, 8'h42, 3, 1'b0, 8'd1, 8'd0, 8'd3, 8'h42);

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_leftover: got %0d want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/zxuno_regport_ctrl.md
Name: zxuno_regport_ctrl

Overview:
Sequencer for the ZX-UNO internal register bus. It decodes Z80 I/O cycles on the address port (FC3Bh) and the data port (FD3Bh), and holds the selected register number. It generates the zxuno_regrd, zxuno_regwr and regaddr_changed controls consumed by peripheral register blocks such as the core-ID text reader. It also arbitrates the NDEV peripheral read responses (dout/oe_n pairs) onto a single CPU read path.

Parameters:
ADDR_PORT, 16'hFC3B, full I/O address of the register-select port
DATA_PORT, 16'hFD3B, full I/O address of the register-data port
NDEV, 4, number of peripheral read sources, 1..8
IDLE_BYTE, 8'hFF, byte returned on a data-port read that no device claims

Ports:
clk  in  1  system clock, shared with the CPU core
rst  in  1  asynchronous, active-high reset
a  in  16  CPU address bus
iorq_n  in  1  CPU IORQ, active low
rd_n  in  1  CPU RD, active low
wr_n  in  1  CPU WR, active low
din  in  8  CPU data out
dout  out  8  read data to CPU
oe_n  out  1  low while dout is valid for the CPU
zxuno_addr  out  8  currently selected register
zxuno_regrd  out  1  level: data-port read in progress
zxuno_regwr  out  1  one-cycle write strobe for the data port
regaddr_changed  out  1  one-cycle pulse when zxuno_addr is written
dev_dout  in  8*NDEV  device read data, device i at bits [8i+7:8i]
dev_oe_n  in  NDEV  device read enables, active low
rd_conflict  out  1  sticky flag: more than one device claimed a read

Behaviour:
- Reset, asynchronous, on rst=1: zxuno_addr=00h; regrd, regwr and regaddr_changed = 0; rd_conflict=0; FSM=IDLE; oe_n=1; dout=IDLE_BYTE.
- Decode, combinational:
  - io_rd = !iorq_n & !rd_n
  - io_wr = !iorq_n & !wr_n
  - hit_a = (a==ADDR_PORT)
  - hit_d = (a==DATA_PORT)
  - Any other address is ignored.
- FSM states: IDLE, QUAL, DO_WR, HOLD.
  - IDLE: on io_wr & (hit_a | hit_d), go to QUAL and latch which port was hit.
  - IDLE: on io_rd & hit_d, go to HOLD; zxuno_regrd=1 from the next cycle.
  - QUAL: if the write is still active and the port is unchanged, go to DO_WR (two-cycle qualification filters glitches). Otherwise return to IDLE with no side effects.
  - DO_WR, address port: zxuno_addr<=din and regaddr_changed=1, for exactly one cycle.
  - DO_WR, data port: zxuno_regwr=1 for exactly one cycle; zxuno_addr is unchanged.
  - DO_WR then goes to HOLD.
  - HOLD: stay until !(io_rd|io_wr), then go to IDLE. zxuno_regrd drops on the same edge that leaves HOLD.
  - One strobe per CPU cycle regardless of its length.
- Write to FC3Bh with the same value as current: regaddr_changed still pulses. Peripherals rely on this to restart streams.
- Read path, combinational. oe_n=0 whenever io_rd & (hit_a | hit_d).
  - hit_a: dout = zxuno_addr.
  - hit_d: dout = dev_dout of the lowest index i with dev_oe_n[i]=0. If no device claims, dout = IDLE_BYTE.
  - No read: dout=IDLE_BYTE, oe_n=1.
- rd_conflict: set on any clock where io_rd & hit_d and two or more dev_oe_n are low. Cleared only by rst.
- Simultaneous io_rd & io_wr: treated as a write. Reads are not decoded in that case.
- rst asserted mid-cycle: immediate return to reset values. A pending strobe is not emitted after rst falls.
- Latency: read data is valid in the same cycle as the decode. A write strobe comes exactly 2 clocks after io_wr is first sampled.

Decomposition:
- Shared package zxuno_regbus_pkg holds:
  - port constants 16'hFC3B and 16'hFD3B;
  - register numbers, including COREID=8'hFF;
  - FSM state enum (IDLE, QUAL, DO_WR, HOLD);
  - IDLE_BYTE.
- One sub-module, zxuno_rdmux: parameterised priority mux plus claim counter. It outputs the selected byte, any_claim and multi_claim.

Test Plan:
- Reset with rst=1 mid-HOLD -> zxuno_addr=00h, all strobes 0, oe_n=1; after release, FSM=IDLE and no stray strobe.
- OUT FC3Bh,FFh (write held 4 clk) -> zxuno_addr=FFh, regaddr_changed=1 exactly one cycle, 2 clk after first sample; zxuno_regwr stays 0.
- OUT FD3Bh,5Ah with zxuno_addr=0Bh -> zxuno_regwr=1 for one cycle while din=5Ah; zxuno_addr stays 0Bh; one strobe for a 6-clk write.
- IN FD3Bh, dev_oe_n=1101b with dev1 data 54h -> oe_n=0, dout=54h same cycle; zxuno_regrd high until rd_n rises, then 0; rd_conflict=0.
- IN FD3Bh, dev_oe_n=1100b (dev0=31h, dev1=54h) -> dout=31h, rd_conflict=1 and stays 1; IN FD3Bh, dev_oe_n=1111b -> dout=FFh, oe_n=0.
- One-clock io_wr glitch on FD3Bh; then IN FC3Bh after zxuno_addr=FFh; then OUT FE00h -> glitch gives no strobe and returns to IDLE; IN FC3Bh returns dout=FFh; OUT FE00h gives no strobe and zxuno_addr is unchanged.
